// File: rtl/keypad_pattern_editor.sv
// Keypad/button front end for the mine-matrix display: scans and debounces a 4x4
// keypad, edits a 16-bit pattern, and drives area/dot/switch/finish registers.
module keypad_pattern_editor #(
  parameter int SCAN_DIV   = 5000,
  parameter int DEB_SCANS  = 3,
  parameter int DEB_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  krow,
  output logic [3:0]  kcol,
  input  logic        btn_area,
  input  logic        btn_commit,
  input  logic        btn_clear,
  input  logic        btn_done,
  output logic [2:0]  area,
  output logic [15:0] dot,
  output logic        switch,
  output logic        finish
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int KW = $clog2(DEB_SCANS + 1);
  localparam int BW = $clog2(DEB_CYCLES + 1);

  localparam logic [1:0] S_EDIT   = 2'd0;
  localparam logic [1:0] S_COMMIT = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [3:0]          krow_s1_q, krow_s2_q;
  logic [3:0]          btn_s1_q, btn_s2_q;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [1:0]          cidx_q, cidx_d;
  logic [3:0]          kcol_q, kcol_d;
  logic [15:0]         snap_q, snap_d;
  logic [15:0]         kdeb_q, kdeb_d, kev_q, kev_d;
  logic [15:0][KW-1:0] kcnt_q, kcnt_d;
  logic [3:0]          bdeb_q, bdeb_d, bev_q, bev_d;
  logic [3:0][BW-1:0]  bcnt_q, bcnt_d;
  logic [1:0]          state_q, state_d;
  logic [2:0]          area_q, area_d;
  logic [15:0]         dot_q, dot_d;
  logic                switch_q, switch_d, finish_q, finish_d;
  logic                dwell_end, scan_done;

  assign dwell_end = (dwell_q == DW'(SCAN_DIV - 1));
  assign scan_done = dwell_end && (cidx_q == 2'd3);

  // Snapshot is stored already in dot bit order (pressed = 1), so key events map
  // straight onto the pattern without reordering.
  always_comb begin
    dwell_d = dwell_end ? '0 : dwell_q + DW'(1);
    cidx_d  = dwell_end ? cidx_q + 2'd1 : cidx_q;
    kcol_d  = dwell_end ? ~(4'b0001 << cidx_d) : kcol_q;
    snap_d  = snap_q;
    for (int c = 0; c < 4; c++)
      if (dwell_end && cidx_q == 2'(c))
        for (int r = 0; r < 4; r++) snap_d[15 - (4 * r + c)] = ~krow_s2_q[r];
  end

  always_comb begin
    kdeb_d = kdeb_q;
    kcnt_d = kcnt_q;
    kev_d  = '0;
    if (scan_done) begin
      for (int k = 0; k < 16; k++) begin
        if (snap_d[k] != kdeb_q[k]) begin
          if (kcnt_q[k] == KW'(DEB_SCANS - 1)) begin
            kdeb_d[k] = snap_d[k];
            kcnt_d[k] = '0;
            kev_d[k]  = snap_d[k];
          end else begin
            kcnt_d[k] = kcnt_q[k] + KW'(1);
          end
        end else begin
          kcnt_d[k] = '0;
        end
      end
    end
  end

  // Button index: 0 area, 1 clear, 2 commit, 3 done.
  always_comb begin
    bdeb_d = bdeb_q;
    bcnt_d = bcnt_q;
    bev_d  = '0;
    for (int b = 0; b < 4; b++) begin
      if (btn_s2_q[b] != bdeb_q[b]) begin
        if (bcnt_q[b] == BW'(DEB_CYCLES - 1)) begin
          bdeb_d[b] = btn_s2_q[b];
          bcnt_d[b] = '0;
          bev_d[b]  = btn_s2_q[b];
        end else begin
          bcnt_d[b] = bcnt_q[b] + BW'(1);
        end
      end else begin
        bcnt_d[b] = '0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    area_d   = area_q;
    dot_d    = dot_q;
    switch_d = 1'b0;
    finish_d = finish_q;
    case (state_q)
      S_EDIT: begin
        if (bev_q[3]) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end else if (bev_q[2]) begin
          state_d  = S_COMMIT;
          switch_d = 1'b1;
        end else if (bev_q[0]) begin
          area_d = area_q + 3'd1;
        end else if (bev_q[1]) begin
          dot_d = '0;
        end else begin
          dot_d = dot_q ^ kev_q;
        end
      end
      S_COMMIT: begin
        dot_d   = '0;
        state_d = S_EDIT;
      end
      S_DONE:  ;
      default: state_d = S_EDIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      krow_s1_q <= 4'hF;
      krow_s2_q <= 4'hF;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      dwell_q   <= '0;
      cidx_q    <= '0;
      kcol_q    <= 4'b1110;
      snap_q    <= '0;
      kdeb_q    <= '0;
      kcnt_q    <= '0;
      kev_q     <= '0;
      bdeb_q    <= '0;
      bcnt_q    <= '0;
      bev_q     <= '0;
      state_q   <= S_EDIT;
      area_q    <= '0;
      dot_q     <= '0;
      switch_q  <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      krow_s1_q <= krow;
      krow_s2_q <= krow_s1_q;
      btn_s1_q  <= {btn_done, btn_commit, btn_clear, btn_area};
      btn_s2_q  <= btn_s1_q;
      dwell_q   <= dwell_d;
      cidx_q    <= cidx_d;
      kcol_q    <= kcol_d;
      snap_q    <= snap_d;
      kdeb_q    <= kdeb_d;
      kcnt_q    <= kcnt_d;
      kev_q     <= kev_d;
      bdeb_q    <= bdeb_d;
      bcnt_q    <= bcnt_d;
      bev_q     <= bev_d;
      state_q   <= state_d;
      area_q    <= area_d;
      dot_q     <= dot_d;
      switch_q  <= switch_d;
      finish_q  <= finish_d;
    end
  end

  assign kcol   = kcol_q;
  assign area   = area_q;
  assign dot    = dot_q;
  assign switch = switch_q;
  assign finish = finish_q;
endmodule

// File: tb/tb_keypad_pattern_editor.sv
// Directed bench for keypad_pattern_editor with a behavioural 4x4 keypad model.
module tb_keypad_pattern_editor;
  logic        clk, rst_n;
  logic [3:0]  krow, kcol;
  logic [3:0]  btn;  // 0 area, 1 clear, 2 commit, 3 done
  logic [2:0]  area;
  logic [15:0] dot;
  logic        sw, fin;
  logic [3:0][3:0] keys;  // keys[r][c] = 1 when pressed
  int n_chk, n_err, sw_cnt, sw0;
  logic [2:0] exp_area;
  logic [3:0] prev_kcol;
  logic seen;

  keypad_pattern_editor #(.SCAN_DIV(4), .DEB_SCANS(2), .DEB_CYCLES(8)) dut (
    .clock(clk), .reset(rst_n), .krow(krow), .kcol(kcol),
    .btn_area(btn[0]), .btn_commit(btn[2]), .btn_clear(btn[1]), .btn_done(btn[3]),
    .area(area), .dot(dot), .switch(sw), .finish(fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb
    for (int r = 0; r < 4; r++) krow[r] = ~|(keys[r] & ~kcol);

  always @(negedge clk) if (sw) sw_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic btn_pulse(input int b);
    btn[b] = 1'b1;
    wait_cyc(10);
    btn[b] = 1'b0;
    wait_cyc(10);
  endtask

  initial begin
    n_chk = 0; n_err = 0; sw_cnt = 0;
    keys = '0; btn = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    wait_cyc(3);
    check("rst_kcol", kcol, 4'b1110);
    check("rst_area", area, 0);
    check("rst_dot", dot, 0);
    check("rst_switch", sw, 0);
    check("rst_finish", fin, 0);
    rst_n = 1'b1;
    check("scan0", kcol, 4'b1110);
    wait_cyc(4); check("scan1", kcol, 4'b1101);
    wait_cyc(4); check("scan2", kcol, 4'b1011);
    wait_cyc(4); check("scan3", kcol, 4'b0111);
    wait_cyc(4); check("scan_wrap", kcol, 4'b1110);

    // Key (0,0) toggles the top-left cell; release and hold do nothing
    keys[0][0] = 1'b1; wait_cyc(64); check("key00_press", dot, 16'h8000);
    wait_cyc(64); check("key00_held", dot, 16'h8000);
    keys[0][0] = 1'b0; wait_cyc(64); check("key00_release", dot, 16'h8000);
    keys[0][0] = 1'b1; wait_cyc(64); check("key00_again", dot, 16'h0000);
    keys[0][0] = 1'b0; wait_cyc(64);
    keys[3][3] = 1'b1; wait_cyc(64); check("key33_press", dot, 16'h0001);
    keys[3][3] = 1'b0; wait_cyc(64);
    btn_pulse(1); check("clear", dot, 16'h0000);

    exp_area = 3'd0;
    for (int i = 0; i < 9; i++) begin
      btn_pulse(0);
      exp_area = exp_area + 3'd1;
      check("area_step", area, exp_area);
    end
    for (int i = 0; i < 4; i++) btn_pulse(0);
    check("area_5", area, 3'd5);

    keys[0][0] = 1'b1; keys[1][1] = 1'b1; keys[2][2] = 1'b1; keys[3][3] = 1'b1;
    wait_cyc(64); check("multi_key", dot, 16'h8421);
    keys = '0; wait_cyc(64); check("multi_release", dot, 16'h8421);

    // Commit: one switch cycle with EDIT values, then the pattern clears
    sw0 = sw_cnt; seen = 1'b0;
    btn[2] = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (sw) begin
        seen = 1'b1;
        check("commit_area", area, 3'd5);
        check("commit_dot", dot, 16'h8421);
        @(negedge clk);
        check("commit_sw_drop", sw, 0);
        check("commit_dot_clr", dot, 16'h0000);
        check("commit_area_hold", area, 3'd5);
      end
    end
    check("commit_seen", seen, 1);
    btn[2] = 1'b0; wait_cyc(12);
    check("commit_pulses", sw_cnt - sw0, 1);

    sw0 = sw_cnt;
    btn[2] = 1'b1; btn[0] = 1'b1; wait_cyc(10);
    btn = '0; wait_cyc(10);
    check("commit_vs_area_sw", sw_cnt - sw0, 1);
    check("commit_vs_area_area", area, 3'd5);

    keys[3][3] = 1'b1; wait_cyc(64); keys = '0; wait_cyc(64);
    check("preset_0001", dot, 16'h0001);
    // Align the key flip of (1,0) and the clear flip on the same edge
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      prev_kcol = kcol;
      @(negedge clk);
      if (prev_kcol == 4'b0111 && kcol == 4'b1110) seen = 1'b1;
    end
    check("align_found", seen, 1);
    keys[1][0] = 1'b1;
    wait_cyc(22);
    btn[1] = 1'b1; wait_cyc(10); btn[1] = 1'b0; wait_cyc(30);
    check("clear_vs_key", dot, 16'h0000);
    keys = '0; wait_cyc(64);
    check("clear_vs_key_rel", dot, 16'h0000);

    keys[0][0] = 1'b1; wait_cyc(64); keys = '0; wait_cyc(64);
    check("preset_8000", dot, 16'h8000);
    btn_pulse(3);
    check("done_finish", fin, 1);
    sw0 = sw_cnt;
    keys[1][1] = 1'b1; wait_cyc(64); keys = '0; wait_cyc(64);
    btn_pulse(0);
    btn_pulse(2);
    btn_pulse(1);
    check("done_dot", dot, 16'h8000);
    check("done_area", area, 3'd5);
    check("done_finish_hold", fin, 1);
    check("done_no_switch", sw_cnt - sw0, 0);

    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (kcol != 4'b1110) seen = 1'b1;
    end
    check("midscan_found", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_kcol", kcol, 4'b1110);
    check("mrst_area", area, 0);
    check("mrst_dot", dot, 0);
    check("mrst_switch", sw, 0);
    check("mrst_finish", fin, 0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
